id_ex_stage: RTL



---
 rtl/pipe_pkg.sv | 30 +++
 rtl/operand_fwd.sv | 29 ++
 rtl/id_ex_stage.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the 16-bit, four-register pipelined CPU.
// Holds datapath widths, the ALU opcode set and the pipeline bubble constant.
package pipe_pkg;

  localparam int WORD_W = 16;
  localparam int REG_W  = 2;
  localparam int OP_W   = 4;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD   = 4'h0,
    ALU_SUB   = 4'h1,
    ALU_AND   = 4'h2,
    ALU_OR    = 4'h3,
    ALU_XOR   = 4'h4,
    ALU_SLL   = 4'h5,
    ALU_SRL   = 4'h6,
    ALU_PASSB = 4'h7
  } alu_op_e;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } ctrl_t;

  // Every pipeline register loads this to kill an instruction.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/operand_fwd.sv
// Combinational operand select: MEM forward, then WB forward, then RF data.
// WB forwarding also covers the same-cycle RF write that the read port misses.
module operand_fwd
  import pipe_pkg::*;
#(
  parameter int WORD_W_P = WORD_W,
  parameter int REG_W_P  = REG_W
) (
  input  logic [REG_W_P-1:0]  src,
  input  logic [WORD_W_P-1:0] rf_data,
  input  logic                mem_reg_write,
  input  logic [REG_W_P-1:0]  mem_rd,
  input  logic [WORD_W_P-1:0] mem_result,
  input  logic                wb_reg_write,
  input  logic [REG_W_P-1:0]  wb_rd,
  input  logic [WORD_W_P-1:0] wb_data,
  output logic [WORD_W_P-1:0] operand
);

  always_comb begin
    operand = rf_data;
    if (mem_reg_write && (mem_rd == src)) begin
      operand = mem_result;
    end else if (wb_reg_write && (wb_rd == src)) begin
      operand = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: operand forwarding, distance-1 hazard stall, ID/EX
// register and a saturating stall-cycle counter.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int WORD_W_P = WORD_W,
  parameter int REG_W_P  = REG_W,
  parameter int OP_W_P   = OP_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [REG_W_P-1:0]  id_rs,
  input  logic [REG_W_P-1:0]  id_rt,
  input  logic                id_use_rs,
  input  logic                id_use_rt,
  input  logic [WORD_W_P-1:0] id_rf_data1,
  input  logic [WORD_W_P-1:0] id_rf_data2,
  input  logic [REG_W_P-1:0]  id_rd,
  input  logic [WORD_W_P-1:0] id_imm,
  input  logic [OP_W_P-1:0]   id_op,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                id_mem_write,
  input  logic                ex_flush,
  input  logic                mem_reg_write,
  input  logic [REG_W_P-1:0]  mem_rd,
  input  logic [WORD_W_P-1:0] mem_result,
  input  logic                wb_reg_write,
  input  logic [REG_W_P-1:0]  wb_rd,
  input  logic [WORD_W_P-1:0] wb_data,
  output logic                stall,
  output logic                ex_valid,
  output logic [WORD_W_P-1:0] ex_opa,
  output logic [WORD_W_P-1:0] ex_opb,
  output logic [WORD_W_P-1:0] ex_imm,
  output logic [OP_W_P-1:0]   ex_op,
  output logic [REG_W_P-1:0]  ex_rd,
  output logic                ex_reg_write,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic [15:0]         stall_count
);

  logic [WORD_W_P-1:0] opa_fwd;
  logic [WORD_W_P-1:0] opb_fwd;
  logic                hazard;
  logic                bubble;
  ctrl_t               ctrl_q;

  operand_fwd #(.WORD_W_P(WORD_W_P), .REG_W_P(REG_W_P)) u_fwd_rs (
    .src           (id_rs),
    .rf_data       (id_rf_data1),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .operand       (opa_fwd)
  );

  operand_fwd #(.WORD_W_P(WORD_W_P), .REG_W_P(REG_W_P)) u_fwd_rt (
    .src           (id_rt),
    .rf_data       (id_rf_data2),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .operand       (opb_fwd)
  );

  // Any EX producer (loads included) has no usable result until MEM.
  always_comb begin
    hazard = id_valid && ctrl_q.valid && ctrl_q.reg_write &&
             ((id_use_rs && (ex_rd == id_rs)) ||
              (id_use_rt && (ex_rd == id_rt)));
    stall  = hazard && !ex_flush;
    bubble = ex_flush || stall || !id_valid;
  end

  // Data fields load every cycle; only the control word is gated by bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= CTRL_BUBBLE;
      ex_opa <= '0;
      ex_opb <= '0;
      ex_imm <= '0;
      ex_op  <= '0;
      ex_rd  <= '0;
    end else begin
      ex_opa <= opa_fwd;
      ex_opb <= opb_fwd;
      ex_imm <= id_imm;
      ex_op  <= id_op;
      ex_rd  <= id_rd;
      if (bubble) begin
        ctrl_q <= CTRL_BUBBLE;
      end else begin
        ctrl_q <= '{valid: 1'b1, reg_write: id_reg_write,
                    mem_read: id_mem_read, mem_write: id_mem_write};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

  assign ex_valid     = ctrl_q.valid;
  assign ex_reg_write = ctrl_q.reg_write;
  assign ex_mem_read  = ctrl_q.mem_read;
  assign ex_mem_write = ctrl_q.mem_write;

endmodule
